// File: rtl/fmdll_pkg.sv
// Shared types, defaults and request validation for the fractional clock-enable generator.
// Channel state is stored at the widest supported ratio width (16 bits) so one struct serves all builds.
package fmdll_pkg;

    localparam int unsigned FMDLL_CH       = 4;
    localparam int unsigned FMDLL_M_W      = 4;
    localparam int unsigned FMDLL_N_W      = 4;
    localparam int unsigned FMDLL_LOCK_CNT = 4;
    localparam int unsigned FMDLL_MAX_W    = 16;
    localparam int unsigned FMDLL_CNT_W    = 8;

    typedef struct packed {
        logic [FMDLL_MAX_W-1:0] m_reg;
        logic [FMDLL_MAX_W-1:0] n_reg;
        logic [FMDLL_MAX_W:0]   acc;
        logic [FMDLL_CNT_W-1:0] cnt;
    } ch_state_t;

    function automatic logic cfg_reject(input int unsigned ch, input int unsigned m,
                                        input int unsigned n, input int unsigned num_ch);
        return (ch >= num_ch) || (n == 0) || (m > n);
    endfunction

endpackage

// File: rtl/fmdll_frac_gen_if.sv
// Ratio configuration handshake between a requester (master) and the generator (slave).
interface fmdll_frac_gen_if
    import fmdll_pkg::*;
#(
    parameter int unsigned CH  = FMDLL_CH,
    parameter int unsigned M_W = FMDLL_M_W,
    parameter int unsigned N_W = FMDLL_N_W
);
    localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [M_W-1:0]  cfg_m;
    logic [N_W-1:0]  cfg_n;
    logic            cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_m, cfg_n,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_m, cfg_n,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/fmdll_frac_ch.sv
// One fractional channel: phase accumulator, saturating lock counter and registered output.
// FMDLL_SQUARE_EN turns the per-overflow enable pulse into a toggling square wave.
module fmdll_frac_ch
    import fmdll_pkg::*;
#(
    parameter int unsigned M_W      = FMDLL_M_W,
    parameter int unsigned N_W      = FMDLL_N_W,
    parameter int unsigned LOCK_CNT = FMDLL_LOCK_CNT
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_apply,
    input  logic [M_W-1:0] i_m,
    input  logic [N_W-1:0] i_n,
    output logic           o_ovf,
    output logic           o_active,
    output logic           o_clk,
    output logic           o_lock
);
    localparam int unsigned ACC_W = FMDLL_MAX_W + 1;

    ch_state_t        r_st;
    ch_state_t        w_st_d;
    logic             r_out;
    logic             w_out_d;
    logic             r_lock;
    logic             w_lock_d;
    logic [ACC_W-1:0] w_sum;
    logic [ACC_W-1:0] w_n_ext;

    assign o_active = (r_st.m_reg != '0);
    assign w_sum    = r_st.acc + ACC_W'(r_st.m_reg);
    assign w_n_ext  = ACC_W'(r_st.n_reg);
    assign o_ovf    = o_active && (w_sum >= w_n_ext);

    always_comb begin
        w_st_d = r_st;
        if (i_apply) begin
            w_st_d.m_reg = FMDLL_MAX_W'(i_m);
            w_st_d.n_reg = FMDLL_MAX_W'(i_n);
            w_st_d.acc   = '0;
            w_st_d.cnt   = '0;
        end else if (o_active) begin
            w_st_d.acc = o_ovf ? (w_sum - w_n_ext) : w_sum;
            if (o_ovf && (r_st.cnt != FMDLL_CNT_W'(LOCK_CNT))) begin
                w_st_d.cnt = r_st.cnt + 1'b1;
            end
        end
        w_lock_d = (w_st_d.cnt == FMDLL_CNT_W'(LOCK_CNT));
    end

`ifdef FMDLL_SQUARE_EN
    always_comb begin
        w_out_d = r_out;
        if (i_apply) begin
            w_out_d = 1'b0;
        end else if (o_ovf) begin
            w_out_d = ~r_out;
        end
    end
`else
    // An apply landing on an overflow edge still emits that old-ratio pulse.
    always_comb begin
        w_out_d = o_ovf;
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_st.m_reg <= '0;
            r_st.n_reg <= FMDLL_MAX_W'(1);
            r_st.acc   <= '0;
            r_st.cnt   <= '0;
            r_out      <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_st   <= w_st_d;
            r_out  <= w_out_d;
            r_lock <= w_lock_d;
        end
    end

    assign o_clk  = r_out;
    assign o_lock = r_lock;

endmodule

// File: rtl/fmdll_frac_gen.sv
// Multi-channel fractional clock-enable generator: handshake, validation, pending slot, apply routing.
// Define FMDLL_SQUARE_EN for square-wave outputs instead of one-cycle enables.
module fmdll_frac_gen
    import fmdll_pkg::*;
#(
    parameter int unsigned CH       = FMDLL_CH,
    parameter int unsigned M_W      = FMDLL_M_W,
    parameter int unsigned N_W      = FMDLL_N_W,
    parameter int unsigned LOCK_CNT = FMDLL_LOCK_CNT
) (
    input  logic            CLK_exit,
    input  logic            rst_n,
    fmdll_frac_gen_if.slave cfg,
    output logic [CH-1:0]   CLK_out,
    output logic [CH-1:0]   lock
);
    localparam int unsigned CH_W = (CH > 1) ? $clog2(CH) : 1;

    logic            r_pending;
    logic [CH_W-1:0] r_pend_ch;
    logic [M_W-1:0]  r_pend_m;
    logic [N_W-1:0]  r_pend_n;
    logic            r_err;
    logic            w_xfer;
    logic            w_reject;
    logic [CH-1:0]   w_ovf;
    logic [CH-1:0]   w_active;
    logic [CH-1:0]   w_apply;

    assign cfg.cfg_ready = ~r_pending;
    assign cfg.cfg_err   = r_err;
    assign w_xfer        = cfg.cfg_valid & ~r_pending;
    assign w_reject      = cfg_reject(32'(cfg.cfg_ch), 32'(cfg.cfg_m), 32'(cfg.cfg_n), CH);

    // A running channel only takes its new ratio on an overflow so no phase is cut short.
    always_comb begin
        w_apply = '0;
        for (int i = 0; i < CH; i++) begin
            w_apply[i] = r_pending && (r_pend_ch == CH_W'(i)) && (!w_active[i] || w_ovf[i]);
        end
    end

    always_ff @(posedge CLK_exit or posedge rst_n) begin
        if (rst_n) begin
            r_pending <= 1'b0;
            r_pend_ch <= '0;
            r_pend_m  <= '0;
            r_pend_n  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_xfer & w_reject;
            if (w_xfer && !w_reject) begin
                r_pending <= 1'b1;
                r_pend_ch <= cfg.cfg_ch;
                r_pend_m  <= cfg.cfg_m;
                r_pend_n  <= cfg.cfg_n;
            end else if (|w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        fmdll_frac_ch #(
            .M_W      (M_W),
            .N_W      (N_W),
            .LOCK_CNT (LOCK_CNT)
        ) u_ch (
            .i_clk    (CLK_exit),
            .i_rst    (rst_n),
            .i_apply  (w_apply[g]),
            .i_m      (r_pend_m),
            .i_n      (r_pend_n),
            .o_ovf    (w_ovf[g]),
            .o_active (w_active[g]),
            .o_clk    (CLK_out[g]),
            .o_lock   (lock[g])
        );
    end

endmodule

// File: doc/fmdll_frac_gen.md
# fmdll_frac_gen

Multi-channel fractional clock-enable generator that succeeds the single-channel fixed-ratio FMDLL. It runs from the CLK_exit domain and drives CH independent outputs. Each output pulses at an average rate of M/N of CLK_exit, using a phase accumulator. Per-channel ratios are reprogrammed at runtime through a valid/ready handshake, and a per-channel lock flag tells downstream logic when the new ratio is active and stable.

## Interface
- CH, 4: number of output channels (1..16).
- M_W, 4: width of the multiplier numerator M.
- N_W, 4: width of the divisor N; M_W ≤ N_W.
- LOCK_CNT, 4: output pulses required after a ratio load before lock asserts (1..255).
- CLK_exit  in  1  sole clock.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1).
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  block can accept a request.
- cfg_ch  in  $clog2(CH) (min 1)  target channel.
- cfg_m  in  M_W  new numerator; 0 disables the channel.
- cfg_n  in  N_W  new divisor.
- cfg_err  out  1  one-cycle flag: request rejected.
- CLK_out  out  CH  per-channel enable pulse (square wave with macro).
- lock  out  CH  channel locked to its current ratio.

## Operation
- Per-channel registers: m_reg (reset 0 = disabled), n_reg (reset 1), acc of N_W+1 bits (reset 0), pulse counter (reset 0).
- Accumulation runs every edge while m_reg≠0: s = acc + m_reg.
  - If s ≥ n_reg: acc ← s − n_reg and the channel pulses.
  - Otherwise acc ← s.
- Handshake and pending slot:
  - A request transfers on an edge with cfg_valid && cfg_ready.
  - cfg_ready = ~pending. There is a single pending slot.
- Validation happens at transfer. The request is rejected if any of these holds: cfg_ch ≥ CH; cfg_n = 0; cfg_m > cfg_n.
  - Rejected requests are discarded, and cfg_err is high for the following cycle.
  - No pending entry is created and channel state is unaffected.
- Applying a pending request:
  - If the target channel is disabled, it applies on the next edge.
  - Otherwise it applies on the first edge where that channel overflows. That overflow pulse is still issued using the old ratio.
  - Apply action: load m_reg and n_reg, set acc ← 0, clear the pulse counter and lock, clear pending.
- Lock:
  - The pulse counter saturates at LOCK_CNT.
  - lock[ch] is high while the counter equals LOCK_CNT.
  - A disabled channel holds lock 0 and CLK_out 0.
- M = N gives CLK_out high every cycle once running.

## Timing
- Reset values: CLK_out 0, lock 0, cfg_err 0, cfg_ready 1, pending 0, all channels disabled.
- All outputs are registered; there are no combinational input-to-output paths.
- Request transferred at edge E0 to a disabled channel:
  - Applied at E1.
  - First accumulate at E2.
  - CLK_out[ch] reflects the overflow decided at edge Ek in the cycle after Ek.
- The new request flag (cfg_ready) rises in the cycle after the apply edge.
- Reset asserted mid-operation immediately clears all state, including a pending request. The first edge after deassertion behaves as post-reset.
- A request arriving on the same edge as an apply is legal: cfg_ready is still 0 that cycle, so it waits.
- cfg_err and an accepted request can never occur on the same edge.

## Configuration
- FMDLL_SQUARE_EN defined: each CLK_out bit toggles on every overflow, giving a square wave at rate M/(2N).
  - Lock counts toggles.
  - The apply action also forces the output low.
- FMDLL_SQUARE_EN undefined: CLK_out is a one-cycle-high enable per overflow.

## Structure
- Package fmdll_pkg holds:
  - The channel-state struct (m_reg, n_reg, acc, cnt).
  - The validation function.
  - The default parameter constants.
- One natural sub-module, fmdll_frac_ch, generated CH times. It contains the accumulator, lock counter and output register, and takes apply/m/n inputs.
- The top level holds the handshake, validation, pending slot and apply routing.

## Test plan
- Reset with rst_n=1 for 3 cycles, then 0 → CLK_out=0, lock=0, cfg_ready=1, cfg_err=0. No pulses for 20 cycles.
- Load ch0 with M=3, N=10 (pulse mode) → pulses at E5, E8, E11, E15 relative to acceptance E0; exactly 3 pulses per 10-cycle window thereafter; lock rises after the 4th pulse.
- Load ch1 with M=1, N=1 → CLK_out[1] high every cycle from the cycle after E2; lock after 4 cycles.
- Reload running ch0 (3/10) with 1/4 → old-ratio pulse at the next overflow, then pulses every 4 cycles; lock drops, then reasserts after 4 new pulses; cfg_ready low exactly until the apply edge.
- Send cfg_n=0, then cfg_m=5/cfg_n=4, then cfg_ch=CH → cfg_err high one cycle for each; running channels keep their pulse pattern unchanged.
- Assert reset mid-run with a request pending; repeat with FMDLL_SQUARE_EN and 1/2 → all state cleared and no stale apply after release; in square mode, output period is 4 cycles with 50% duty.
